// File: rtl/divider_seq.sv
// divider_seq: iterative unsigned restoring divider producing one quotient
// bit per clock. A controller pulses start with the operands, watches busy,
// and collects quotient/remainder on the one-cycle done pulse. A zero
// divisor completes at once with quotient all ones, remainder = dividend
// and div_by_zero set.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        launch request, sampled on rising clk edge
//   dividend     unsigned dividend, sampled with an accepted start
//   divisor      unsigned divisor, sampled with an accepted start
//   busy         high while a division is in progress
//   done         one-cycle pulse, results valid
//   quotient     unsigned quotient (held until the next completion)
//   remainder    unsigned remainder (held until the next completion)
//   div_by_zero  set with done when the captured divisor was zero
module divider_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pr;    // partial remainder
  logic [WIDTH-1:0] dq;    // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH:0]   pr_ext;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] pr_next;
  logic [WIDTH-1:0] dq_next;

  // One restoring step. pr < dvsr always holds, so the shifted value fits in
  // WIDTH+1 bits, and a restored (negative-trial) value fits in WIDTH bits.
  always_comb begin
    pr_ext  = {pr, dq[WIDTH-1]};
    trial   = pr_ext - {1'b0, dvsr};
    pr_next = trial[WIDTH] ? pr_ext[WIDTH-1:0] : trial[WIDTH-1:0];
    dq_next = {dq[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      pr          <= '0;
      dq          <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvsr <= divisor;
            dq   <= dividend;
            pr   <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              count <= CW'(WIDTH);
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          pr    <= pr_next;
          dq    <= dq_next;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state       <= DONE;
            quotient    <= dq_next;
            remainder   <= pr_next;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int failures;

  divider_seq #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands at the falling edge, let the next rising edge sample
  // them, then drop start and scramble the operands (they are don't-care).
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Advance one cycle at a time until done is seen; lat counts edges after
  // the launch edge, busy_cnt counts sampled cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cnt, output bit timeout);
    lat = 0;
    busy_cnt = 0;
    timeout = 1'b0;
    while (!done) begin
      if (busy) busy_cnt++;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    bit to;
    logic [3:0] a_t [4] = '{4'd13, 4'd7, 4'd15, 4'd0};
    logic [3:0] b_t [4] = '{4'd3,  4'd9, 4'd1,  4'd5};
    logic [3:0] q_t [4] = '{4'd4,  4'd0, 4'd15, 4'd0};
    logic [3:0] r_t [4] = '{4'd1,  4'd7, 4'd0,  4'd0};
    for (int i = 0; i < 4; i++) begin
      launch(a_t[i], b_t[i]);
      wait_done(lat, bc, to);
      checks++;
      if (to || lat != 4 || bc != 4) begin
        failures++;
        $display("FAIL basic_timing[%0d]: got lat=%0d busy_cycles=%0d timeout=%0b, want 4 4 0",
                 i, lat, bc, to);
      end
      checks++;
      if (quotient !== q_t[i] || remainder !== r_t[i] || div_by_zero !== 1'b0) begin
        failures++;
        $display("FAIL basic_result[%0d]: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=0",
                 i, quotient, remainder, div_by_zero, q_t[i], r_t[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || quotient !== q_t[i] || remainder !== r_t[i]) begin
        failures++;
        $display("FAIL basic_hold[%0d]: got done=%0b q=%0d r=%0d, want done=0 q=%0d r=%0d",
                 i, done, quotient, remainder, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit to;
    launch(4'd9, 4'd0);
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 0 || bc != 0) begin
      failures++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d timeout=%0b, want 0 0 0", lat, bc, to);
    end
    checks++;
    if (quotient !== 4'hF || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%0b, want q=15 r=9 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    launch(4'd8, 4'd2);
    checks++;
    if (div_by_zero !== 1'b1 || quotient !== 4'hF) begin
      failures++;
      $display("FAIL dbz_hold_in_calc: got q=%0d dbz=%0b, want q=15 dbz=1", quotient, div_by_zero);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || quotient !== 4'd4 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%0b timeout=%0b, want q=4 r=0 dbz=0",
               quotient, remainder, div_by_zero, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit to;
    launch(4'd14, 4'd4);
    @(posedge clk);
    #1;
    launch(4'd3, 4'd1);   // lands on the second CALC edge, must be ignored
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_hold: got q=%0d r=%0d busy=%0b, want q=4 r=0 busy=1",
               quotient, remainder, busy);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 2) begin
      failures++;
      $display("FAIL ignore_timing: got lat=%0d timeout=%0b, want 2 0", lat, to);
    end
    checks++;
    if (quotient !== 4'd3 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result: got q=%0d r=%0d dbz=%0b, want q=3 r=2 dbz=0",
               quotient, remainder, div_by_zero);
    end
    launch(4'd12, 4'd5);  // start asserted during the DONE cycle
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_single_done: got done=%0b busy=%0b, want done=0 busy=1", done, busy);
    end
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 4 || quotient !== 4'd2 || remainder !== 4'd2) begin
      failures++;
      $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d timeout=%0b, want lat=4 q=2 r=2",
               lat, quotient, remainder, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    bit to;
    int seen;
    launch(4'd11, 4'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles after release, want 0", seen);
    end
    launch(4'd11, 4'd2);
    wait_done(lat, bc, to);
    checks++;
    if (to || lat != 4 || quotient !== 4'd5 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL after_abort: got lat=%0d q=%0d r=%0d dbz=%0b, want lat=4 q=5 r=1 dbz=0",
               lat, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exhaustive();
    int lat, bc;
    bit to;
    logic [3:0] eq, er;
    logic       ed;
    int         exp_lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF; er = 4'(a); ed = 1'b1; exp_lat = 0;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); ed = 1'b0; exp_lat = 4;
        end
        launch(4'(a), 4'(b));   // issued in the prior DONE cycle: back-to-back
        wait_done(lat, bc, to);
        checks++;
        if (to || lat != exp_lat || quotient !== eq || remainder !== er || div_by_zero !== ed) begin
          failures++;
          $display("FAIL exh %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%0b to=%0b, want lat=%0d q=%0d r=%0d dbz=%0b",
                   a, b, lat, quotient, remainder, div_by_zero, to, exp_lat, eq, er, ed);
        end
        if (b != 0) begin
          checks++;
          if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
            failures++;
            $display("FAIL invariant %0d/%0d: got q=%0d r=%0d, want q*d+r=%0d and r<%0d",
                     a, b, quotient, remainder, a, b);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
